// File: rtl/fpu_soma_ctrl.sv
// fpu_soma_ctrl: sequencing FSM for a float add/subtract datapath.
// Aligns the smaller operand one bit per cycle, adds, normalizes one bit
// per cycle, rounds to nearest-even and renormalizes on a round carry.
module fpu_soma_ctrl #(
    parameter int N_exp  = 8,
    parameter int N_mant = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_exp-1:0] diferenca_exp,
    input  logic             big_cout,
    input  logic             res_msb,
    input  logic             res_zero,
    input  logic             guard,
    input  logic             sticky,
    input  logic             lsb,
    input  logic             exp_max,
    output logic             BigAlu_in_A,
    output logic             BigAlu_in_B,
    output logic             ShiftDif_amount,
    output logic             Exp_sel,
    output logic             ShiftNorm_sel,
    output logic             ShiftNorm_amount,
    output logic             Increment_sel,
    output logic             Increment_amount,
    output logic             Roud_amount,
    output logic             busy,
    output logic             done,
    output logic             zero_flag,
    output logic             ovf_flag
);

    localparam int CW = $clog2(N_mant + 3);
    localparam int NW = $clog2(N_mant + 2);

    typedef enum logic [2:0] {
        IDLE, ALIGN, ADD, NORM, ROUND, RENORM, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] align_cnt_q, align_cnt_d;
    logic [NW-1:0] norm_cnt_q, norm_cnt_d;
    logic          exp_sel_q, exp_sel_d;
    logic          zero_flag_q, zero_flag_d;
    logic          ovf_flag_q, ovf_flag_d;

    logic [N_exp:0]  dif_ext;
    logic [N_exp:0]  dif_abs;
    logic [CW-1:0]   align_init;

    // Magnitude of the exponent difference at one extra bit, saturated to N_mant+2
    always_comb begin
        dif_ext = {diferenca_exp[N_exp-1], diferenca_exp};
        dif_abs = diferenca_exp[N_exp-1] ? (~dif_ext + 1'b1) : dif_ext;
        if (32'(dif_abs) > 32'(N_mant + 2))
            align_init = CW'(N_mant + 2);
        else
            align_init = CW'(dif_abs);
    end

    // Next-state, counter and flag updates plus combinational strobes
    always_comb begin
        state_d          = state_q;
        align_cnt_d      = align_cnt_q;
        norm_cnt_d       = norm_cnt_q;
        exp_sel_d        = exp_sel_q;
        zero_flag_d      = zero_flag_q;
        ovf_flag_d       = ovf_flag_q;
        BigAlu_in_A      = 1'b0;
        BigAlu_in_B      = 1'b0;
        ShiftDif_amount  = 1'b0;
        ShiftNorm_sel    = 1'b0;
        ShiftNorm_amount = 1'b0;
        Increment_sel    = 1'b0;
        Increment_amount = 1'b0;
        Roud_amount      = 1'b0;
        done             = 1'b0;
        busy             = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_sel_d   = diferenca_exp[N_exp-1];
                    align_cnt_d = align_init;
                    norm_cnt_d  = '0;
                    zero_flag_d = 1'b0;
                    ovf_flag_d  = 1'b0;
                    state_d     = (align_init != '0) ? ALIGN : ADD;
                end
            end
            ALIGN: begin
                ShiftDif_amount = 1'b1;
                align_cnt_d     = align_cnt_q - 1'b1;
                if (align_cnt_q == CW'(1))
                    state_d = ADD;
            end
            ADD: begin
                BigAlu_in_A = 1'b1;
                BigAlu_in_B = 1'b1;
                state_d     = NORM;
            end
            NORM: begin
                if (big_cout) begin
                    ShiftNorm_amount = 1'b1;
                    Increment_amount = 1'b1;
                    state_d          = ROUND;
                end else if (res_zero) begin
                    zero_flag_d = 1'b1;
                    state_d     = DONE;
                end else if (norm_cnt_q == NW'(N_mant + 1)) begin
                    state_d = ROUND;
                end else if (!res_msb) begin
                    ShiftNorm_sel    = 1'b1;
                    ShiftNorm_amount = 1'b1;
                    Increment_sel    = 1'b1;
                    Increment_amount = 1'b1;
                    norm_cnt_d       = norm_cnt_q + 1'b1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (guard & (sticky | lsb)) begin
                    Roud_amount = 1'b1;
                    state_d     = RENORM;
                end else begin
                    state_d = DONE;
                end
            end
            RENORM: begin
                if (big_cout) begin
                    ShiftNorm_amount = 1'b1;
                    Increment_amount = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // DONE never follows itself, so this fires only on entry
        if (state_d == DONE && state_q != DONE)
            ovf_flag_d = exp_max;
    end

    // State, counters and flags register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            align_cnt_q <= '0;
            norm_cnt_q  <= '0;
            exp_sel_q   <= 1'b0;
            zero_flag_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            norm_cnt_q  <= norm_cnt_d;
            exp_sel_q   <= exp_sel_d;
            zero_flag_q <= zero_flag_d;
            ovf_flag_q  <= ovf_flag_d;
        end
    end

    assign Exp_sel   = exp_sel_q;
    assign zero_flag = zero_flag_q;
    assign ovf_flag  = ovf_flag_q;

endmodule

// File: tb/tb_fpu_soma_ctrl.sv
// tb_fpu_soma_ctrl: directed vector table, randomized scenarios against a
// path-level model, and hand sequences for reset abort and held start.
module tb_fpu_soma_ctrl;

    localparam int NE = 8;
    localparam int NM = 23;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NE-1:0] dif;
    logic          big_cout, res_msb, res_zero, guard, sticky, lsb, exp_max;
    logic          BigAlu_in_A, BigAlu_in_B, ShiftDif_amount, Exp_sel;
    logic          ShiftNorm_sel, ShiftNorm_amount, Increment_sel, Increment_amount;
    logic          Roud_amount, busy, done, zero_flag, ovf_flag;

    fpu_soma_ctrl #(.N_exp(NE), .N_mant(NM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .diferenca_exp(dif),
        .big_cout(big_cout), .res_msb(res_msb), .res_zero(res_zero),
        .guard(guard), .sticky(sticky), .lsb(lsb), .exp_max(exp_max),
        .BigAlu_in_A(BigAlu_in_A), .BigAlu_in_B(BigAlu_in_B),
        .ShiftDif_amount(ShiftDif_amount), .Exp_sel(Exp_sel),
        .ShiftNorm_sel(ShiftNorm_sel), .ShiftNorm_amount(ShiftNorm_amount),
        .Increment_sel(Increment_sel), .Increment_amount(Increment_amount),
        .Roud_amount(Roud_amount), .busy(busy), .done(done),
        .zero_flag(zero_flag), .ovf_flag(ovf_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] dif;
        bit cout, zero;
        int k;
        bit gd, st, lb, carry, emax, hold;
    } scn_t;

    typedef struct {
        int align, left, rsh, rnd, lat;
        bit zf, ovf, esel;
    } exp_t;

    typedef struct {
        scn_t s;
        exp_t e;
    } vec_t;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [12:0] out_vec();
        return {BigAlu_in_A, BigAlu_in_B, ShiftDif_amount, Exp_sel, ShiftNorm_sel,
                ShiftNorm_amount, Increment_sel, Increment_amount, Roud_amount,
                busy, done, zero_flag, ovf_flag};
    endfunction

    // Path-level model: which operations the add must perform and how long it takes
    function automatic exp_t model(input scn_t s);
        exp_t e;
        int d, mag;
        bit r;
        d      = int'($signed(s.dif));
        mag    = (d < 0) ? -d : d;
        e.align = (mag > NM + 2) ? NM + 2 : mag;
        e.esel  = (d < 0);
        e.ovf   = s.emax;
        e.zf    = 1'b0;
        e.rsh   = 0;
        e.rnd   = 0;
        if (!s.cout && s.zero) begin
            e.left = s.k;
            e.zf   = 1'b1;
            e.lat  = 3 + e.align + e.left;
            return e;
        end
        if (s.cout) begin
            e.left = 0;
            e.rsh  = 1;
        end else begin
            e.left = (s.k > NM + 1) ? NM + 1 : s.k;
        end
        r      = s.gd && (s.st || s.lb);
        e.rnd  = r ? 1 : 0;
        e.rsh  = e.rsh + ((r && s.carry) ? 1 : 0);
        e.lat  = 4 + e.align + e.left + e.rnd;
        return e;
    endfunction

    // Plays the datapath: status bits react to strobes already issued
    task automatic run_op(input vec_t v, input string tag);
        int sdif, ain, bin, lsh, dec, rsh, inc, rnd, busy_n, dcyc, xdone, xbusy;
        bit got;
        sdif = 0; ain = 0; bin = 0; lsh = 0; dec = 0; rsh = 0; inc = 0; rnd = 0;
        busy_n = 0; dcyc = -1; xdone = 0; xbusy = 0; got = 1'b0;
        @(negedge clk);
        dif = v.s.dif; guard = v.s.gd; sticky = v.s.st; lsb = v.s.lb; exp_max = v.s.emax;
        big_cout = 1'b0; res_msb = 1'b0; res_zero = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            start    = v.s.hold;
            big_cout = (rnd > 0) ? v.s.carry : ((ain > 0) ? v.s.cout : 1'b0);
            res_zero = v.s.zero && (lsh >= v.s.k);
            res_msb  = !v.s.zero && (lsh >= v.s.k);
            #1;
            sdif   += int'(ShiftDif_amount);
            ain    += int'(BigAlu_in_A);
            bin    += int'(BigAlu_in_B);
            lsh    += int'(ShiftNorm_amount && ShiftNorm_sel);
            rsh    += int'(ShiftNorm_amount && !ShiftNorm_sel);
            dec    += int'(Increment_amount && Increment_sel);
            inc    += int'(Increment_amount && !Increment_sel);
            rnd    += int'(Roud_amount);
            busy_n += int'(busy);
            if (done) begin
                got   = 1'b1;
                dcyc  = c;
                start = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            xdone += int'(done);
            xbusy += int'(busy);
        end
        chk($sformatf("%s latency", tag), dcyc, v.e.lat);
        chk($sformatf("%s busy_cycles", tag), busy_n, v.e.lat);
        chk($sformatf("%s align_shifts", tag), sdif, v.e.align);
        chk($sformatf("%s alu_load", tag), ain + 2 * bin, 3);
        chk($sformatf("%s left_shifts", tag), lsh, v.e.left);
        chk($sformatf("%s decrements", tag), dec, v.e.left);
        chk($sformatf("%s right_shifts", tag), rsh, v.e.rsh);
        chk($sformatf("%s increments", tag), inc, v.e.rsh);
        chk($sformatf("%s round", tag), rnd, v.e.rnd);
        chk($sformatf("%s exp_sel", tag), int'(Exp_sel), int'(v.e.esel));
        chk($sformatf("%s zero_flag", tag), int'(zero_flag), int'(v.e.zf));
        chk($sformatf("%s ovf_flag", tag), int'(ovf_flag), int'(v.e.ovf));
        chk($sformatf("%s extra_done", tag), xdone, 0);
        chk($sformatf("%s idle_busy", tag), xbusy, 0);
    endtask

    vec_t tbl[10];
    vec_t rv;
    int   nd;

    initial begin
        //            dif    cout zero k  gd st lb cy em hold    align left rsh rnd lat zf ovf esel
        tbl[0] = '{'{8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 4, 0, 0, 0}};
        tbl[1] = '{'{8'hFD, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{3, 0, 0, 0, 7, 0, 0, 1}};
        tbl[2] = '{'{8'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{25, 0, 0, 0, 29, 0, 0, 1}};
        tbl[3] = '{'{8'h02, 1, 0, 0, 1, 0, 1, 1, 0, 0}, '{2, 0, 2, 1, 7, 0, 0, 0}};
        tbl[4] = '{'{8'h00, 0, 1, 5, 0, 0, 0, 0, 0, 0}, '{0, 5, 0, 0, 8, 1, 0, 0}};
        tbl[5] = '{'{8'h7F, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{25, 0, 0, 0, 29, 0, 0, 0}};
        tbl[6] = '{'{8'h05, 0, 0, 3, 1, 1, 0, 0, 1, 0}, '{5, 3, 0, 1, 13, 0, 1, 0}};
        tbl[7] = '{'{8'h01, 0, 0, 30, 1, 0, 0, 0, 0, 0}, '{1, 24, 0, 0, 29, 0, 0, 0}};
        tbl[8] = '{'{8'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 0}, '{1, 0, 0, 0, 5, 0, 1, 1}};
        tbl[9] = '{'{8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 4, 0, 0, 0}};

        rst_n = 1'b0; start = 1'b0; dif = '0; big_cout = 1'b0; res_msb = 1'b0;
        res_zero = 1'b0; guard = 1'b0; sticky = 1'b0; lsb = 1'b0; exp_max = 1'b0;
        #2;
        chk("reset outputs", int'(out_vec()), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Abort mid-ALIGN: outputs drop asynchronously, no done pulse follows
        @(negedge clk);
        dif = 8'hFA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("abort pre busy", int'(busy), 1);
        chk("abort pre shift", int'(ShiftDif_amount), 1);
        rst_n = 1'b0;
        #1;
        chk("abort outputs", int'(out_vec()), 0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            nd += int'(done);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            nd += int'(done) + int'(busy);
        end
        chk("abort no done", nd, 0);
        run_op(tbl[1], "post_reset");

        for (int n = 0; n < 40; n++) begin
            rv.s.dif   = 8'($urandom_range(0, 255));
            rv.s.cout  = ($urandom_range(0, 2) == 0);
            rv.s.zero  = !rv.s.cout && ($urandom_range(0, 3) == 0);
            rv.s.k     = rv.s.zero ? $urandom_range(0, 8) : $urandom_range(0, 28);
            rv.s.gd    = 1'($urandom_range(0, 1));
            rv.s.st    = 1'($urandom_range(0, 1));
            rv.s.lb    = 1'($urandom_range(0, 1));
            rv.s.carry = 1'($urandom_range(0, 1));
            rv.s.emax  = 1'($urandom_range(0, 1));
            rv.s.hold  = ($urandom_range(0, 4) == 0);
            rv.e       = model(rv.s);
            run_op(rv, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
